max_min_scan_ip: RTL
====================

MAX_MIN_SCAN_IP -- requirements
Module: max_min_scan_ip

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits, legal range 2..32.
REQ-002 Parameter DEPTH, default 16, element buffer entries, power of two, legal range 2..256.
REQ-003 Port iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port iReset  input  1  reset, synchronous and active-high.
REQ-005 Port iChipselect_n  input  1  bus select, active-low.
REQ-006 Port iWrite_n  input  1  write strobe, active-low, qualified by iChipselect_n.
REQ-007 Port iRead_n  input  1  read strobe, active-low, qualified by iChipselect_n.
REQ-008 Port iAddress  input  3  register select.
REQ-009 Port iData  input  32  write data.
REQ-010 Port oData  output  32  registered read data.

Function
REQ-011 Register map SHALL be:
- 0 CTRL: W bit0 START (self-clearing pulse), bit1 MODE (0 max, 1 min), bit2 SIGNED (0 unsigned, 1 two's-complement); R returns {29'd0, SIGNED, MODE, 1'b0}.
- 1 STATUS: R {29'd0, OVF, DONE, BUSY}; W bit1=1 clears DONE, W bit2=1 clears OVF.
- 2 COUNT: R number of loaded elements, zero-extended; any W sets COUNT to 0.
- 3 PUSH: W stores iData[DATA_W-1:0] at buffer[COUNT], COUNT increments.
- 4 RESULT: R winning value, sign-extended if SIGNED, else zero-extended.
- 5 INDEX: R winning buffer index, zero-extended.
- 6, 7: R 0, W ignored.
REQ-012 Reads SHALL update oData one edge after the sampled read strobe; oData SHALL hold its value when there is no read.
REQ-013 PUSH with COUNT==DEPTH SHALL discard the data, leave COUNT unchanged and set OVF.
REQ-014 The FSM SHALL have states IDLE and SCAN; BUSY=1 exactly in SCAN.
REQ-015 START in IDLE with COUNT>=1 SHALL latch MODE/SIGNED, load best=buffer[0], idx=0, ptr=1 and enter SCAN on the same edge.
REQ-016 Each SCAN cycle SHALL compare buffer[ptr] against best, strictly greater for max or strictly less for min, and replace best/idx on a win; on ties the lowest index wins.
REQ-017 SCAN SHALL exit to IDLE on the edge that processes ptr==COUNT-1, setting DONE and updating RESULT/INDEX on that edge; BUSY lasts COUNT-1 cycles, and with COUNT==1 the block SHALL go straight to IDLE with DONE set.
REQ-018 START with COUNT==0 SHALL set DONE and OVF, and leave RESULT/INDEX unchanged.
REQ-019 START, PUSH, COUNT writes and CTRL mode writes while BUSY SHALL be ignored; STATUS clears and all reads remain functional.
REQ-020 A new START SHALL clear DONE on the same edge it is accepted.
REQ-021 Simultaneous read and write in one cycle SHALL perform both; the read returns the pre-write value.

Reset
REQ-022 iReset SHALL set oData=0, FSM=IDLE, COUNT=0, DONE=0, OVF=0, MODE=0, SIGNED=0, RESULT=0 and INDEX=0; buffer contents are not reset.
REQ-023 iReset asserted during SCAN SHALL abort the scan on that edge, without setting DONE.

Structure
REQ-024 Register address constants, CTRL/STATUS bit positions and the MODE encodings SHALL live in shared package max_scan_pkg.
REQ-025 The signed/unsigned max/min comparator SHALL be the combinational sub-module scan_cmp (inputs a, b, mode, signed; output a_wins).
REQ-026 The buffer SHALL be a DEPTH x DATA_W register array with one write port and one read port.

Verification
REQ-027 Push 3,9,4,9; START with MODE=0 and SIGNED=0 -> BUSY for 3 cycles, then DONE=1, RESULT=9, INDEX=1.
REQ-028 Push 8'hFE, 8'h05, 8'h80; START with MODE=1 and SIGNED=1 -> RESULT=32'hFFFFFF80, INDEX=2; repeat with SIGNED=0 -> RESULT=5, INDEX=1.
REQ-029 Push DEPTH+1 elements -> COUNT=DEPTH, OVF=1; write STATUS 4 -> OVF=0.
REQ-030 With COUNT=0, START -> DONE=1, OVF=1, BUSY never asserted.
REQ-031 START with COUNT=16, then PUSH and START mid-scan, then assert iReset on the 5th BUSY cycle -> pushes and START ignored while BUSY; after reset BUSY=0, DONE=0, COUNT=0, oData=0.

Source files
------------

// File: rtl/max_scan_pkg.sv
// Shared register map, bit positions, mode encodings and FSM state type
// for the max/min scan block.
package max_scan_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_COUNT  = 3'd2;
    localparam logic [2:0] ADDR_PUSH   = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_INDEX  = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_SIGNED = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    // Bits at and above 'width' become copies of the element's top bit when
    // sign_ext is set, otherwise zero.
    function automatic logic [31:0] extend_word(input logic [31:0] value,
                                                input int          width,
                                                input logic        sign_ext);
        logic [31:0] word;
        word = value;
        for (int i = 0; i < 32; i++) begin
            if (i >= width) begin
                word[i] = sign_ext & value[width-1];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/scan_cmp.sv
// Combinational max/min comparator: a_wins when candidate a strictly beats
// the current best b under the selected ordering.
module scan_cmp
    import max_scan_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode,
    input  logic              signed_mode,
    output logic              a_wins
);

    logic a_gt;
    logic a_lt;

    always_comb begin
        if (signed_mode) begin
            a_gt = $signed(a) > $signed(b);
            a_lt = $signed(a) < $signed(b);
        end else begin
            a_gt = a > b;
            a_lt = a < b;
        end
        // Strict comparison keeps the earlier index on ties.
        a_wins = 1'b0;
        case (mode)
            MODE_MAX: a_wins = a_gt;
            MODE_MIN: a_wins = a_lt;
        endcase
    end

endmodule

// File: rtl/max_min_scan_ip.sv
// Bus-mapped element buffer with a sequential max/min scanner that walks
// one element per clock and reports the winning value and its index.
module max_min_scan_ip
    import max_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
)
(
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iChipselect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [2:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] buffer [DEPTH];

    scan_state_t       state;
    logic [CNT_W-1:0]  count;
    logic              done;
    logic              ovf;
    logic              mode;
    logic              sgn;
    logic              scan_mode;
    logic              scan_sgn;
    logic [DATA_W-1:0] best;
    logic [IDX_W-1:0]  best_idx;
    logic [IDX_W-1:0]  ptr;
    logic [31:0]       result;
    logic [IDX_W-1:0]  index;

    logic              bus_wr;
    logic              bus_rd;
    logic              busy;
    logic              ctrl_wr;
    logic              start_req;
    logic              status_wr;
    logic              count_wr;
    logic              push_wr;
    logic              push_ok;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_elem;
    logic              cand_wins;
    logic [DATA_W-1:0] next_best;
    logic [IDX_W-1:0]  next_idx;
    logic              last_elem;
    logic [31:0]       read_word;
    logic              unused_data;

    assign bus_wr    = !iChipselect_n && !iWrite_n;
    assign bus_rd    = !iChipselect_n && !iRead_n;
    assign busy      = (state == SCAN);

    // Everything that changes the scan's inputs is locked out while busy;
    // STATUS clears stay live so software can acknowledge at any time.
    assign ctrl_wr   = bus_wr && (iAddress == ADDR_CTRL)  && !busy;
    assign start_req = ctrl_wr && iData[CTRL_START];
    assign status_wr = bus_wr && (iAddress == ADDR_STATUS);
    assign count_wr  = bus_wr && (iAddress == ADDR_COUNT) && !busy;
    assign push_wr   = bus_wr && (iAddress == ADDR_PUSH)  && !busy;
    assign push_ok   = push_wr && (count != FULL);

    assign unused_data = ^iData;

    // Single read port: element 0 while idle (seed for START), ptr while scanning.
    assign rd_addr   = busy ? ptr : '0;
    assign rd_elem   = buffer[rd_addr];

    scan_cmp #(
        .DATA_W(DATA_W)
    ) u_cmp (
        .a          (rd_elem),
        .b          (best),
        .mode       (scan_mode),
        .signed_mode(scan_sgn),
        .a_wins     (cand_wins)
    );

    assign next_best = cand_wins ? rd_elem : best;
    assign next_idx  = cand_wins ? ptr : best_idx;
    assign last_elem = (CNT_W'(ptr) == (count - CNT_W'(1)));

    always_ff @(posedge iClk) begin
        if (push_ok) begin
            buffer[count[IDX_W-1:0]] <= iData[DATA_W-1:0];
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= IDLE;
            count     <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            mode      <= MODE_MAX;
            sgn       <= 1'b0;
            scan_mode <= MODE_MAX;
            scan_sgn  <= 1'b0;
            best      <= '0;
            best_idx  <= '0;
            ptr       <= '0;
            result    <= '0;
            index     <= '0;
        end else begin
            if (status_wr) begin
                if (iData[STAT_DONE]) done <= 1'b0;
                if (iData[STAT_OVF])  ovf  <= 1'b0;
            end
            if (count_wr) begin
                count <= '0;
            end
            if (push_wr) begin
                if (push_ok) count <= count + CNT_W'(1);
                else         ovf   <= 1'b1;
            end
            if (ctrl_wr) begin
                mode <= iData[CTRL_MODE];
                sgn  <= iData[CTRL_SIGNED];
            end

            // FSM updates come last so a completing scan's DONE wins over a
            // same-cycle STATUS clear.
            case (state)
                IDLE: begin
                    if (start_req) begin
                        if (count == '0) begin
                            done <= 1'b1;
                            ovf  <= 1'b1;
                        end else begin
                            scan_mode <= iData[CTRL_MODE];
                            scan_sgn  <= iData[CTRL_SIGNED];
                            best      <= rd_elem;
                            best_idx  <= '0;
                            ptr       <= IDX_W'(1);
                            if (count == CNT_W'(1)) begin
                                done   <= 1'b1;
                                result <= extend_word(32'(rd_elem), DATA_W, iData[CTRL_SIGNED]);
                                index  <= '0;
                            end else begin
                                done  <= 1'b0;
                                state <= SCAN;
                            end
                        end
                    end
                end
                SCAN: begin
                    best     <= next_best;
                    best_idx <= next_idx;
                    if (last_elem) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        result <= extend_word(32'(next_best), DATA_W, scan_sgn);
                        index  <= next_idx;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_word = '0;
        case (iAddress)
            ADDR_CTRL:   read_word = {29'd0, sgn, mode, 1'b0};
            ADDR_STATUS: read_word = {29'd0, ovf, done, busy};
            ADDR_COUNT:  read_word = 32'(count);
            ADDR_RESULT: read_word = result;
            ADDR_INDEX:  read_word = 32'(index);
            default:     read_word = '0;
        endcase
    end

    // Read data is captured from pre-edge state, so a same-cycle write is
    // not visible until the following read.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oData <= '0;
        end else if (bus_rd) begin
            oData <= read_word;
        end
    end

endmodule
